// File: rtl/tamarac_datapath_p.sv
// Parametrised Tamarac accumulator datapath: registers, ALU with latched flags, GPIO window.
// Define TAMARAC_IO_EVENT_EN to build the per-channel input change capture behind io_event.
module tamarac_datapath_p #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned NUM_IO      = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_IO*DATA_W-1:0] switches,
  input  logic [1:0]               alucntl,
  input  logic                     rsw,
  input  logic                     rmem,
  input  logic                     rpc,
  input  logic                     racc,
  input  logic                     rir,
  input  logic                     rbuf,
  input  logic                     wmar,
  input  logic                     wmem,
  input  logic                     wpc,
  input  logic                     wacc,
  input  logic                     wir,
  input  logic                     warg,
  input  logic                     wbuf,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic [2:0]               opc,
  output logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-1:0]        acc,
  output logic [NUM_IO*DATA_W-1:0] leds,
  output logic [2:0]               flags,
  output logic                     io_event
);

  // Outputs occupy the first NUM_IO words of the window, inputs the last NUM_IO.
  localparam logic [ADDR_W-1:0] IoBase = ADDR_W'((1 << ADDR_W) - 2 * NUM_IO);

  logic [ADDR_W-1:0]                        mar_q, pc_q;
  logic [DATA_W-1:0]                        acc_q, ir_q, arg_q, bufr_q;
  logic [NUM_IO*DATA_W-1:0]                 leds_q;
  logic [2:0]                               flags_q;
  logic [SYNC_STAGES-1:0][NUM_IO*DATA_W-1:0] sync_q;
  logic [NUM_IO*DATA_W-1:0]                 sw_s;
  logic [NUM_IO-1:0]                        out_hit, in_hit;
  logic [DATA_W-1:0]                        data_rd, databus, alu_res;
  logic [DATA_W:0]                          alu_wide;
  logic                                     alu_c;

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    data_rd = mem_rdata;
    for (int k = 0; k < NUM_IO; k++) begin
      out_hit[k] = (mar_q == IoBase + ADDR_W'(k));
      in_hit[k]  = (mar_q == IoBase + ADDR_W'(NUM_IO + k));
      if (out_hit[k]) data_rd = leds_q[k*DATA_W +: DATA_W];
      if (in_hit[k])  data_rd = sw_s[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    if (rsw)       databus = sw_s[DATA_W-1:0];
    else if (rmem) databus = data_rd;
    else if (rpc)  databus = DATA_W'(pc_q);
    else if (racc) databus = acc_q;
    else if (rir)  databus = ir_q;
    else if (rbuf) databus = bufr_q;
    else           databus = '0;
  end

  // The extra top bit carries the add carry-out or the subtract borrow.
  always_comb begin
    alu_wide = '0;
    case (alucntl)
      2'b00:   alu_wide = {1'b0, arg_q} + {1'b0, databus};
      2'b01:   alu_wide = {1'b0, arg_q} - {1'b0, databus};
      2'b10:   alu_wide = {1'b0, arg_q & databus};
      default: alu_wide = {1'b0, databus};
    endcase
  end

  assign alu_res = alu_wide[DATA_W-1:0];
  assign alu_c   = alu_wide[DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mar_q   <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      arg_q   <= '0;
      bufr_q  <= '0;
      leds_q  <= '0;
      flags_q <= '0;
    end else begin
      if (wmar) mar_q <= databus[ADDR_W-1:0];
      if (wpc)  pc_q  <= databus[ADDR_W-1:0];
      if (wacc) acc_q <= databus;
      if (wir)  ir_q  <= databus;
      if (warg) arg_q <= databus;
      if (wbuf) begin
        bufr_q  <= alu_res;
        flags_q <= {alu_c, alu_res[DATA_W-1], (alu_res == '0)};
      end
      for (int k = 0; k < NUM_IO; k++) begin
        if (wmem && out_hit[k]) leds_q[k*DATA_W +: DATA_W] <= databus;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], switches};
  end

`ifdef TAMARAC_IO_EVENT_EN
  logic [NUM_IO*DATA_W-1:0] sw_prev_q;
  logic [NUM_IO-1:0]        chg_q, chg_d;

  // Clear first so a change seen in the clearing cycle still sets the bit.
  always_comb begin
    chg_d = chg_q;
    for (int k = 0; k < NUM_IO; k++) begin
      if ((rmem && in_hit[k]) || (k == 0 && rsw)) chg_d[k] = 1'b0;
      if (sw_s[k*DATA_W +: DATA_W] != sw_prev_q[k*DATA_W +: DATA_W]) chg_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_prev_q <= '0;
      chg_q     <= '0;
    end else begin
      sw_prev_q <= sw_s;
      chg_q     <= chg_d;
    end
  end

  assign io_event = |chg_q;
`else
  assign io_event = 1'b0;
`endif

  assign mem_addr  = mar_q;
  assign mem_wdata = databus;
  assign mem_we    = wmem & ~(|out_hit) & ~(|in_hit);
  assign opc       = ir_q[DATA_W-1 -: 3];
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign leds      = leds_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_tamarac_datapath_p.sv
// Self-checking bench for tamarac_datapath_p with two GPIO channels; expected values are
// queued when stimulus is driven and compared when the DUT result becomes visible.
module tb_tamarac_datapath_p;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 13;
  localparam int unsigned NIO = 2;
  localparam int unsigned SS  = 2;

  localparam logic [12:0] S_RSW  = 13'h1000;
  localparam logic [12:0] S_RMEM = 13'h0800;
  localparam logic [12:0] S_RPC  = 13'h0400;
  localparam logic [12:0] S_RACC = 13'h0200;
  localparam logic [12:0] S_RIR  = 13'h0100;
  localparam logic [12:0] S_RBUF = 13'h0080;
  localparam logic [12:0] S_WMAR = 13'h0040;
  localparam logic [12:0] S_WMEM = 13'h0020;
  localparam logic [12:0] S_WPC  = 13'h0010;
  localparam logic [12:0] S_WACC = 13'h0008;
  localparam logic [12:0] S_WIR  = 13'h0004;
  localparam logic [12:0] S_WARG = 13'h0002;
  localparam logic [12:0] S_WBUF = 13'h0001;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [NIO*DW-1:0]  switches = '0;
  logic [1:0]         alucntl = 2'b00;
  logic [12:0]        strb = '0;
  logic [DW-1:0]      mem_rdata = '0;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic [2:0]         opc;
  logic [AW-1:0]      pc;
  logic [DW-1:0]      acc;
  logic [NIO*DW-1:0]  leds;
  logic [2:0]         flags;
  logic               io_event;

  int unsigned        total = 0;
  int unsigned        bad = 0;
  logic [DW+2:0]      exp_q[$];
  logic [DW+2:0]      e;

  always #5 clock = ~clock;

  tamarac_datapath_p #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .NUM_IO      (NIO),
    .SYNC_STAGES (SS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .switches  (switches),
    .alucntl   (alucntl),
    .rsw       (strb[12]),
    .rmem      (strb[11]),
    .rpc       (strb[10]),
    .racc      (strb[9]),
    .rir       (strb[8]),
    .rbuf      (strb[7]),
    .wmar      (strb[6]),
    .wmem      (strb[5]),
    .wpc       (strb[4]),
    .wacc      (strb[3]),
    .wir       (strb[2]),
    .warg      (strb[1]),
    .wbuf      (strb[0]),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .opc       (opc),
    .pc        (pc),
    .acc       (acc),
    .leds      (leds),
    .flags     (flags),
    .io_event  (io_event)
  );

  task automatic drive(input logic [12:0] s, input logic [DW-1:0] rd);
    strb      = s;
    mem_rdata = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    strb = '0;
  endtask

  task automatic do_reset;
    strb     = '0;
    switches = '0;
    alucntl  = 2'b00;
    reset_n  = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Reference ALU: {result, C, N, Z}
  function automatic logic [DW+2:0] alu_ref(input logic [1:0] m, input int unsigned a,
                                            input int unsigned b);
    int unsigned r;
    logic        c;
    case (m)
      2'd0:    begin r = a + b; c = (r > 32'hFFFF); end
      2'd1:    begin r = a - b; c = (a < b); end
      2'd2:    begin r = a & b; c = 1'b0; end
      default: begin r = b; c = 1'b0; end
    endcase
    r = r & 32'hFFFF;
    return {r[15:0], c, r[15], (r[15:0] == 16'h0)};
  endfunction

  task automatic test_reset;
    do_reset;
    drive(S_RMEM | S_WACC, 16'h1234); tick;
    drive(S_RMEM | S_WPC, 16'h0123);  tick;
    drive(S_RMEM | S_WBUF, 16'h0000); tick;
    drive(S_RMEM | S_WIR, 16'hE000);  tick;
    drive(S_RMEM | S_WMAR, 16'h0042); tick;
    total++;
    if (acc !== 16'h1234) begin bad++; $display("FAIL rst_pre_acc got=%h exp=1234", acc); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (acc !== '0) begin bad++; $display("FAIL rst_acc got=%h exp=0", acc); end
    total++;
    if (pc !== '0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    total++;
    if (flags !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", flags); end
    total++;
    if ({opc, mem_addr} !== '0) begin
      bad++; $display("FAIL rst_opc_addr got=%h/%h exp=0/0", opc, mem_addr);
    end
    total++;
    if ({leds, mem_we, mem_wdata, io_event} !== '0) begin
      bad++; $display("FAIL rst_misc got=%h/%b/%h/%b exp=0", leds, mem_we, mem_wdata, io_event);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick;
    total++;
    if ({pc, flags} !== '0) begin bad++; $display("FAIL rst_release got=%h/%b exp=0", pc, flags); end
  endtask

  task automatic test_alu;
    logic [1:0]  md [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [15:0] va [6] = '{16'hFFFF, 16'h0003, 16'hF0F0, 16'h1234, 16'h0005, 16'h7FFF};
    logic [15:0] vb [6] = '{16'h0001, 16'h0005, 16'hFF00, 16'h0000, 16'h0003, 16'h0001};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      alucntl = md[i];
      drive(S_RMEM | S_WARG, va[i]); tick;
      drive(S_RMEM | S_WBUF, vb[i]);
      exp_q.push_back(alu_ref(md[i], va[i], vb[i]));
      tick;
      drive(S_RBUF, 16'h0000);
      e = exp_q.pop_front();
      total++;
      if ({mem_wdata, flags} !== e) begin
        bad++; $display("FAIL alu_%0d got=%h/%b exp=%h/%b", i, mem_wdata, flags, e[18:3], e[2:0]);
      end
    end
    drive(S_RMEM | S_WACC | S_WARG, 16'h0000); tick;
    total++;
    if (flags !== e[2:0]) begin bad++; $display("FAIL flags_hold got=%b exp=%b", flags, e[2:0]); end
  endtask

  task automatic test_gpio;
    do_reset;
    drive(S_RMEM | S_WACC, 16'hA5A5); tick;
    drive(S_RMEM | S_WIR, 16'h5A5A);  tick;
    drive(S_RMEM | S_WPC, 16'd8189);  tick;
    alucntl = 2'b11;
    drive(S_RMEM | S_WBUF, 16'd100);  tick;
    drive(S_RMEM | S_WMAR, 16'd8188); tick;
    drive(S_RACC | S_WMEM, 16'h0000);
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL gpio_we0 got=%b exp=0", mem_we); end
    exp_q.push_back(19'(16'hA5A5));
    tick;
    e = exp_q.pop_front();
    total++;
    if (leds[15:0] !== e[15:0]) begin bad++; $display("FAIL gpio_ch0 got=%h exp=%h", leds[15:0], e[15:0]); end
    drive(S_RPC | S_WMAR, 16'h0000); tick;
    total++;
    if (mem_addr !== 13'd8189) begin bad++; $display("FAIL gpio_mar got=%0d exp=8189", mem_addr); end
    drive(S_RIR | S_WMEM, 16'h0000);
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL gpio_we1 got=%b exp=0", mem_we); end
    exp_q.push_back({3'b000, 16'h5A5A});
    tick;
    e = exp_q.pop_front();
    total++;
    if (leds !== {e[15:0], 16'hA5A5}) begin
      bad++; $display("FAIL gpio_ch1 got=%h exp=%h", leds, {e[15:0], 16'hA5A5});
    end
    drive(S_RMEM, 16'h0000);
    total++;
    if (mem_wdata !== 16'h5A5A) begin bad++; $display("FAIL gpio_readback got=%h exp=5a5a", mem_wdata); end
    drive(S_RBUF | S_WMAR, 16'h0000); tick;
    drive(S_RACC | S_WMEM, 16'h0000);
    total++;
    if ({mem_we, mem_addr} !== {1'b1, 13'd100}) begin
      bad++; $display("FAIL gpio_ram_we got=%b/%0d exp=1/100", mem_we, mem_addr);
    end
    tick;
    total++;
    if (leds !== 32'h5A5A_A5A5) begin bad++; $display("FAIL gpio_ram_leds got=%h exp=5a5aa5a5", leds); end
  endtask

  task automatic test_sync;
    do_reset;
    switches[15:0] = 16'h00FF;
    for (int i = 1; i <= int'(SS) + 1; i++) begin
      tick;
      drive(S_RSW, 16'h0000);
      exp_q.push_back((i >= int'(SS)) ? 19'h000FF : 19'h0);
      e = exp_q.pop_front();
      total++;
      if (mem_wdata !== e[15:0]) begin
        bad++; $display("FAIL sync_tick%0d got=%h exp=%h", i, mem_wdata, e[15:0]);
      end
    end
    tick;
    drive(S_RMEM | S_WMAR, 16'd8190); tick;
    drive(S_RMEM | S_WMEM, 16'h0000);
    total++;
    if ({mem_we, mem_wdata} !== {1'b0, 16'h00FF}) begin
      bad++; $display("FAIL sync_memread got=%b/%h exp=0/00ff", mem_we, mem_wdata);
    end
    tick;
    total++;
    if (leds !== '0) begin bad++; $display("FAIL sync_in_write got=%h exp=0", leds); end
  endtask

  task automatic test_io_event;
    do_reset;
`ifdef TAMARAC_IO_EVENT_EN
    drive(S_RMEM | S_WMAR, 16'd8191); tick;
    switches[31:16] = 16'h0001;
    for (int i = 1; i <= int'(SS) + 1; i++) begin
      tick;
      if (i == int'(SS)) begin
        total++;
        if (io_event !== 1'b0) begin bad++; $display("FAIL ev_early got=%b exp=0", io_event); end
      end
    end
    total++;
    if (io_event !== 1'b1) begin bad++; $display("FAIL ev_set got=%b exp=1", io_event); end
    drive(S_RMEM, 16'h0000); tick;
    total++;
    if (io_event !== 1'b0) begin bad++; $display("FAIL ev_clear got=%b exp=0", io_event); end
    switches[31:16] = 16'h0002;
    repeat (SS) tick;
    drive(S_RMEM, 16'h0000); tick;
    total++;
    if (io_event !== 1'b1) begin bad++; $display("FAIL ev_set_wins got=%b exp=1", io_event); end
    drive(S_RMEM, 16'h0000); tick;
    total++;
    if (io_event !== 1'b0) begin bad++; $display("FAIL ev_clear2 got=%b exp=0", io_event); end
    switches[15:0] = 16'h0003;
    repeat (SS + 1) tick;
    total++;
    if (io_event !== 1'b1) begin bad++; $display("FAIL ev_ch0 got=%b exp=1", io_event); end
    drive(S_RSW, 16'h0000); tick;
    total++;
    if (io_event !== 1'b0) begin bad++; $display("FAIL ev_rsw_clear got=%b exp=0", io_event); end
`else
    switches = '1;
    repeat (SS + 2) tick;
    total++;
    if (io_event !== 1'b0) begin bad++; $display("FAIL ev_tied got=%b exp=0", io_event); end
`endif
  endtask

  task automatic test_back_to_back;
    do_reset;
    drive(S_RMEM | S_WACC, 16'h1234); tick;
    switches[15:0] = 16'hBEEF;
    repeat (SS) tick;
    drive(S_RSW | S_RACC | S_WACC, 16'h0000); tick;
    total++;
    if (acc !== 16'hBEEF) begin bad++; $display("FAIL prio_rsw got=%h exp=beef", acc); end
    drive(S_RMEM | S_RACC | S_WACC, 16'h4321); tick;
    total++;
    if (acc !== 16'h4321) begin bad++; $display("FAIL prio_rmem got=%h exp=4321", acc); end
    drive(S_RMEM | S_WACC, 16'd100); tick;
    drive(S_RMEM | S_WMAR, 16'd8188); tick;
    drive(S_RACC | S_WMAR | S_WMEM, 16'h0000);
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL oldmar_we got=%b exp=0", mem_we); end
    tick;
    total++;
    if ({leds[15:0], mem_addr} !== {16'd100, 13'd100}) begin
      bad++; $display("FAIL oldmar got=%h/%0d exp=0064/100", leds[15:0], mem_addr);
    end
    drive(S_RMEM | S_WMEM | S_WACC | S_WIR | S_WARG, 16'h7777);
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL multi_we got=%b exp=1", mem_we); end
    tick;
    total++;
    if ({acc, opc} !== {16'h7777, 3'd3}) begin
      bad++; $display("FAIL multi_capture got=%h/%0d exp=7777/3", acc, opc);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_gpio;
    test_sync;
    test_io_event;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
